// File: rtl/plab4_net_router_pkg.sv
// Shared constants for the ring router: port indices, port count, domain width,
// and the priority rotation helper used by the output arbiters.
package plab4_net_router_pkg;

    localparam int c_num_ports    = 3;
    localparam int c_domain_nbits = 1;

    localparam logic [1:0] c_port_prev = 2'd0;
    localparam logic [1:0] c_port_term = 2'd1;
    localparam logic [1:0] c_port_next = 2'd2;

    // Next priority after a grant: the input just above the winner goes first.
    function automatic logic [c_num_ports-1:0] rotl_prio(input logic [c_num_ports-1:0] winner);
        return {winner[c_num_ports-2:0], winner[c_num_ports-1]};
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// Combinational 3-way round-robin pick: search upward from the one-hot
// priority index, wrapping 2->0, and return the one-hot winner and its index.
module plab4_net_rr_arb3
    import plab4_net_router_pkg::*;
(
    input  logic [c_num_ports-1:0] eligible,
    input  logic [c_num_ports-1:0] prio,
    output logic [c_num_ports-1:0] winner,
    output logic [1:0]             sel
);

    always_comb begin
        winner = '0;
        case (prio)
            3'b010: begin
                if      (eligible[1]) winner = 3'b010;
                else if (eligible[2]) winner = 3'b100;
                else if (eligible[0]) winner = 3'b001;
            end
            3'b100: begin
                if      (eligible[2]) winner = 3'b100;
                else if (eligible[0]) winner = 3'b001;
                else if (eligible[1]) winner = 3'b010;
            end
            // Non-one-hot priority cannot occur from reset; treat it as 3'b001.
            default: begin
                if      (eligible[0]) winner = 3'b001;
                else if (eligible[1]) winner = 3'b010;
                else if (eligible[2]) winner = 3'b100;
            end
        endcase
    end

    always_comb begin
        sel = c_port_prev;
        if (winner[1])      sel = c_port_term;
        else if (winner[2]) sel = c_port_next;
    end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Per-output-port arbitration for the ring router with an optional two-domain
// time-division mode that keeps separate round-robin state per domain.
module plab4_net_router_output_ctrl
    import plab4_net_router_pkg::*;
#(
    parameter int p_num_inputs  = 3,
    parameter int p_tdm_en      = 0,
    parameter int p_slot_cycles = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [p_num_inputs-1:0]   reqs,
    input  logic [p_num_inputs-1:0]   in_domain,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [p_num_inputs-1:0]   grants,
    output logic [1:0]                sel,
    output logic [c_domain_nbits-1:0] cur_domain
);

    localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_cycles - 1);

    logic [p_num_inputs-1:0]   prio0;
    logic [p_num_inputs-1:0]   prio1;
    logic [p_num_inputs-1:0]   prio;
    logic [p_num_inputs-1:0]   eligible;
    logic [p_num_inputs-1:0]   winner;
    logic [1:0]                win_sel;
    logic [c_slot_nbits-1:0]   slot_cnt;
    logic [c_domain_nbits-1:0] domain;
    logic                      xfer;

    // Off-slot requests are masked before arbitration so they never touch priority.
    assign eligible = (p_tdm_en != 0) ? (reqs & ~(in_domain ^ {p_num_inputs{domain}})) : reqs;
    assign prio     = (p_tdm_en != 0 && domain == 1'b1) ? prio1 : prio0;

    plab4_net_rr_arb3 arb (
        .eligible (eligible),
        .prio     (prio),
        .winner   (winner),
        .sel      (win_sel)
    );

    assign out_val    = reset & (|eligible);
    assign grants     = reset ? (winner & {p_num_inputs{out_rdy}}) : '0;
    assign sel        = reset ? win_sel : 2'd0;
    assign cur_domain = domain;
    assign xfer       = out_val & out_rdy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio0 <= 3'b001;
            prio1 <= 3'b001;
        end else if (xfer) begin
            if (p_tdm_en != 0 && domain == 1'b1) prio1 <= rotl_prio(winner);
            else                                 prio0 <= rotl_prio(winner);
        end
    end

    // Slot timing is free-running so it leaks nothing about traffic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt <= '0;
            domain   <= '0;
        end else if (p_tdm_en != 0) begin
            if (slot_cnt == c_slot_last) begin
                slot_cnt <= '0;
                domain   <= ~domain;
            end else begin
                slot_cnt <= slot_cnt + c_slot_nbits'(1);
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Directed and randomized checks of the output control: one plain round-robin
// instance (a) and one TDM instance (b, 4-cycle slots) share the same inputs.
module tb_plab4_net_router_output_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] in_domain;
    logic       out_rdy;

    logic       val_a, val_b;
    logic [2:0] grants_a, grants_b;
    logic [1:0] sel_a, sel_b;
    logic       dom_a, dom_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    plab4_net_router_output_ctrl #(.p_num_inputs(3), .p_tdm_en(0), .p_slot_cycles(8)) dut_a (
        .clk(clk), .reset(reset), .reqs(reqs), .in_domain(in_domain), .out_val(val_a),
        .out_rdy(out_rdy), .grants(grants_a), .sel(sel_a), .cur_domain(dom_a));

    plab4_net_router_output_ctrl #(.p_num_inputs(3), .p_tdm_en(1), .p_slot_cycles(4)) dut_b (
        .clk(clk), .reset(reset), .reqs(reqs), .in_domain(in_domain), .out_val(val_b),
        .out_rdy(out_rdy), .grants(grants_b), .sel(sel_b), .cur_domain(dom_b));

    typedef struct packed {
        logic       ca; logic [2:0] ga; logic [1:0] sa; logic va;
        logic       cb; logic [2:0] gb; logic [1:0] sb; logic vb;
        logic       cd; logic       db;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t mk(input logic ca, input logic [2:0] ga, input logic [1:0] sa, input logic va,
                                input logic cb, input logic [2:0] gb, input logic [1:0] sb, input logic vb,
                                input logic cd, input logic db);
        exp_t e;
        e = '{ca: ca, ga: ga, sa: sa, va: va, cb: cb, gb: gb, sb: sb, vb: vb, cd: cd, db: db};
        return e;
    endfunction

    function automatic logic [2:0] pick(input logic [2:0] el, input logic [2:0] pr);
        int b;
        b = pr[1] ? 1 : (pr[2] ? 2 : 0);
        for (int k = 0; k < 3; k++) begin
            if (el[(b + k) % 3]) return 3'(1 << ((b + k) % 3));
        end
        return 3'b000;
    endfunction

    function automatic logic [1:0] idx(input logic [2:0] w);
        return w[1] ? 2'd1 : (w[2] ? 2'd2 : 2'd0);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus just after the edge, queue its expectation,
    // then compare on the falling edge.
    task automatic step(input string tag, input logic rst, input logic [2:0] r, input logic [2:0] d,
                        input logic rdy, input exp_t e);
        exp_t o;
        @(posedge clk);
        #1;
        reset = rst; reqs = r; in_domain = d; out_rdy = rdy;
        sb_q.push_back(e);
        @(negedge clk);
        o = sb_q.pop_front();
        if (o.ca) begin
            chk({tag, ".grants_a"}, 8'(grants_a), 8'(o.ga));
            chk({tag, ".sel_a"},    8'(sel_a),    8'(o.sa));
            chk({tag, ".val_a"},    8'(val_a),    8'(o.va));
            chk({tag, ".dom_a"},    8'(dom_a),    8'(0));
        end
        if (o.cb) begin
            chk({tag, ".grants_b"}, 8'(grants_b), 8'(o.gb));
            chk({tag, ".sel_b"},    8'(sel_b),    8'(o.sb));
            chk({tag, ".val_b"},    8'(val_b),    8'(o.vb));
        end
        if (o.cd) chk({tag, ".dom_b"}, 8'(dom_b), 8'(o.db));
    endtask

    logic [2:0] mprio_a, mprio0, mprio1, el_a, el_b, wa, wb, r;
    logic [2:0] d;
    logic       mdom, rdy, rst;
    int         mslot;
    int         wait_cnt [3];
    logic [2:0] exp_g [4];
    logic [1:0] exp_s [4];

    initial begin
        reset = 1'b0; reqs = 3'b000; in_domain = 3'b000; out_rdy = 1'b0;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};

        // Reset: outputs forced low even with full requests pending.
        step("rst0", 1'b0, 3'b111, 3'b000, 1'b1, mk(1, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0));
        step("rst1", 1'b0, 3'b111, 3'b000, 1'b1, mk(1, 3'b000, 0, 0, 1, 3'b000, 0, 0, 1, 0));

        // Full requests rotate 001 -> 010 -> 100 -> 001.
        for (int i = 0; i < 4; i++)
            step("rr", 1'b1, 3'b111, 3'b000, 1'b1, mk(1, exp_g[i], exp_s[i], 1, 0, 0, 0, 0, 0, 0));

        // Backpressure: valid and select stay, no grant, priority frozen.
        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, 3'b110, 3'b000, 1'b0, mk(1, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0));
        step("unstall", 1'b1, 3'b110, 3'b000, 1'b1, mk(1, 3'b010, 1, 1, 0, 0, 0, 0, 0, 0));

        // TDM slotting: a domain-1 request only wins during domain-1 slots.
        step("tdm_rst", 1'b0, 3'b001, 3'b001, 1'b1, mk(0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            logic on;
            on = (i >= 4 && i < 8);
            step("tdm_slot", 1'b1, 3'b001, 3'b001, 1'b1,
                 mk(0, 0, 0, 0, 1, on ? 3'b001 : 3'b000, 0, on, 1, on));
        end

        // Domain-0 traffic leaves the domain-1 priority untouched.
        step("iso_rst", 1'b0, 3'b111, 3'b000, 1'b1, mk(0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            step("iso_d0", 1'b1, 3'b111, 3'b000, 1'b1, mk(0, 0, 0, 0, 1, exp_g[i], exp_s[i], 1, 1, 0));
        step("iso_d1a", 1'b1, 3'b111, 3'b111, 1'b1, mk(0, 0, 0, 0, 1, 3'b001, 0, 1, 1, 1));
        step("iso_d1b", 1'b1, 3'b111, 3'b111, 1'b1, mk(0, 0, 0, 0, 1, 3'b010, 1, 1, 1, 1));

        // Reset in the middle of a stream drops the grant and restarts state.
        step("mid_pre", 1'b0, 3'b111, 3'b000, 1'b1, mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
        step("mid_s0", 1'b1, 3'b111, 3'b000, 1'b1, mk(1, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0));
        step("mid_s1", 1'b1, 3'b111, 3'b000, 1'b1, mk(1, 3'b010, 1, 1, 0, 0, 0, 0, 0, 0));
        step("mid_rst", 1'b0, 3'b111, 3'b000, 1'b1, mk(1, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            step("mid_post", 1'b1, 3'b111, 3'b000, 1'b1,
                 mk(1, exp_g[i], exp_s[i], 1, 1, exp_g[i], exp_s[i], 1, 1, 0));
        step("mid_slot", 1'b1, 3'b111, 3'b000, 1'b1, mk(1, 3'b010, 1, 1, 1, 3'b000, 0, 0, 1, 1));

        // Randomized traffic against a reference model of both instances.
        step("rnd_rst", 1'b0, 3'b000, 3'b000, 1'b0, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        mprio_a = 3'b001; mprio0 = 3'b001; mprio1 = 3'b001; mdom = 1'b0; mslot = 0;
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            r   = 3'($urandom);
            d   = 3'($urandom);
            rdy = 1'($urandom);
            el_a = r;
            el_b = r & ~(d ^ {3{mdom}});
            wa = pick(el_a, mprio_a);
            wb = pick(el_b, mdom ? mprio1 : mprio0);
            if (rst)
                step("rand", rst, r, d, rdy, mk(1, wa & {3{rdy}}, idx(wa), |el_a,
                                               1, wb & {3{rdy}}, idx(wb), |el_b, 1, mdom));
            else
                step("rand", rst, r, d, rdy, mk(1, 3'b000, 0, 0, 1, 3'b000, 0, 0, 1, mdom));
            chk("onehot_a", 8'($onehot0(grants_a)), 8'(1));
            chk("onehot_b", 8'($onehot0(grants_b)), 8'(1));
            chk("subset_b", 8'(grants_b & ~el_b), 8'(0));
            if (grants_a != 3'b000) begin
                for (int i = 0; i < 3; i++) begin
                    if (r[i] && rst && !grants_a[i]) wait_cnt[i]++;
                    else                             wait_cnt[i] = 0;
                end
                chk("starve_a", 8'(wait_cnt[0] <= 2 && wait_cnt[1] <= 2 && wait_cnt[2] <= 2), 8'(1));
            end else begin
                for (int i = 0; i < 3; i++) if (!(r[i] && rst)) wait_cnt[i] = 0;
            end
            if (!rst) begin
                mprio_a = 3'b001; mprio0 = 3'b001; mprio1 = 3'b001; mdom = 1'b0; mslot = 0;
                for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
            end else begin
                if (|el_a && rdy) mprio_a = {wa[1:0], wa[2]};
                if (|el_b && rdy) begin
                    if (mdom) mprio1 = {wb[1:0], wb[2]};
                    else      mprio0 = {wb[1:0], wb[2]};
                end
                if (mslot == 3) begin mslot = 0; mdom = ~mdom; end
                else            mslot++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
